// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared MDU definitions: op encodings, request bus width, sequencer states
// and the magnitude helper used by both multiply and divide paths.
package mdu_hilo_ctrl_pkg;

   localparam logic [2:0] MDU_OP_MULT  = 3'd0;
   localparam logic [2:0] MDU_OP_MULTU = 3'd1;
   localparam logic [2:0] MDU_OP_DIV   = 3'd2;
   localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
   localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
   localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

   localparam int MDU_REQ_BUS_WD = 3 + 32 + 32;

   typedef enum logic [1:0] {
      MDU_IDLE    = 2'd0,
      MDU_MUL_RUN = 2'd1,
      MDU_DIV_RUN = 2'd2
   } mdu_state_e;

   // Two's-complement magnitude; 0x80000000 maps to itself, which is the
   // correct unsigned magnitude of -2^31.
   function automatic logic [31:0] mduMagnitude(input logic [31:0] value,
                                                input logic        isSigned);
      return (isSigned && value[31]) ? (32'd0 - value) : value;
   endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_div.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
// Outputs show the quotient/remainder as they will be after the current step.
module mdu_div_iter (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   logic [31:0] quo_q;
   logic [31:0] rem_q;
   logic [31:0] dvs_q;
   logic [32:0] partial;
   logic        fits;
   logic [31:0] diff;

   // The 33-bit partial remainder can exceed 32 bits, but whenever the
   // subtraction is kept its result is below the divisor, so 32 bits suffice.
   assign partial     = {rem_q, quo_q[31]};
   assign fits        = partial >= {1'b0, dvs_q};
   assign diff        = partial[31:0] - dvs_q;
   assign remainder_o = fits ? diff : partial[31:0];
   assign quotient_o  = {quo_q[30:0], fits};

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (start_i) begin
         quo_q <= dividend_i;
         rem_q <= '0;
         dvs_q <= divisor_i;
      end else if (step_i) begin
         quo_q <= quotient_o;
         rem_q <= remainder_o;
      end
   end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// MDU sequencer and HI/LO owner. Define MDU_FAST_MUL_EN for a single-cycle
// multiply; otherwise the multiplier is a 32-step shift-add.
module mdu_hilo_ctrl
   import mdu_hilo_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e  state_q;
   logic [5:0]  cnt_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;
   logic [31:0] srcA_q;
   logic [31:0] srcB_q;
   logic        signed_q;

   logic        accept;
   logic        reqSigned;
   logic        reqIsDiv;
   logic        negQuo;
   logic        negRem;
   logic [31:0] divQuo;
   logic [31:0] divRem;
   logic [31:0] divHi;
   logic [31:0] divLo;
   logic [63:0] mulProd;
   logic        mulLast;

   assign req_ready = (state_q == MDU_IDLE);
   assign busy      = (state_q != MDU_IDLE);
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

   assign accept    = req_valid && req_ready && !cancel;
   assign reqSigned = (req_op == MDU_OP_MULT) || (req_op == MDU_OP_DIV);
   assign reqIsDiv  = (req_op == MDU_OP_DIV) || (req_op == MDU_OP_DIVU);
   assign negQuo    = signed_q & (srcA_q[31] ^ srcB_q[31]);
   assign negRem    = signed_q & srcA_q[31];

   mdu_div_iter u_div (
      .clk         (clk),
      .reset       (reset),
      .start_i     (accept && reqIsDiv),
      .step_i      ((state_q == MDU_DIV_RUN) && !cancel),
      .dividend_i  (mduMagnitude(req_src1, reqSigned)),
      .divisor_i   (mduMagnitude(req_src2, reqSigned)),
      .quotient_o  (divQuo),
      .remainder_o (divRem)
   );

   // Divide by zero returns all-ones quotient and the raw dividend as remainder.
   assign divLo = (srcB_q == 32'd0) ? 32'hFFFF_FFFF : (negQuo ? (32'd0 - divQuo) : divQuo);
   assign divHi = (srcB_q == 32'd0) ? srcA_q        : (negRem ? (32'd0 - divRem) : divRem);

`ifdef MDU_FAST_MUL_EN
   logic signed [65:0] fastProd;
   assign fastProd = $signed({signed_q & srcA_q[31], srcA_q}) *
                     $signed({signed_q & srcB_q[31], srcB_q});
   assign mulProd  = fastProd[63:0];
   assign mulLast  = 1'b1;
`else
   logic [63:0] mulAcc_q;
   logic [63:0] mulAcc_d;
   logic [32:0] mulSum;
   logic [31:0] mcand;
   logic        reqIsMul;

   // Accumulator holds {partial product, remaining multiplier bits}; shifting
   // right each step retires one multiplier bit into the low half.
   assign reqIsMul = (req_op == MDU_OP_MULT) || (req_op == MDU_OP_MULTU);
   assign mcand    = mduMagnitude(srcB_q, signed_q);
   assign mulSum   = {1'b0, mulAcc_q[63:32]} + (mulAcc_q[0] ? {1'b0, mcand} : 33'd0);
   assign mulAcc_d = {mulSum, mulAcc_q[31:1]};
   assign mulProd  = negQuo ? (64'd0 - mulAcc_d) : mulAcc_d;
   assign mulLast  = (cnt_q == 6'd31);

   always_ff @(posedge clk) begin
      if (reset) begin
         mulAcc_q <= '0;
      end else if (accept && reqIsMul) begin
         mulAcc_q <= {32'd0, mduMagnitude(req_src1, reqSigned)};
      end else if (state_q == MDU_MUL_RUN) begin
         mulAcc_q <= mulAcc_d;
      end
   end
`endif

   // Cancel overrides everything, including a request arriving in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= MDU_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         srcA_q   <= '0;
         srcB_q   <= '0;
         signed_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (cancel) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               MDU_IDLE: begin
                  if (req_valid) begin
                     cnt_q <= '0;
                     case (req_op)
                        MDU_OP_MTHI: hi_q <= req_src1;
                        MDU_OP_MTLO: lo_q <= req_src1;
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                           srcA_q   <= req_src1;
                           srcB_q   <= req_src2;
                           signed_q <= reqSigned;
                           state_q  <= MDU_MUL_RUN;
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                           srcA_q   <= req_src1;
                           srcB_q   <= req_src2;
                           signed_q <= reqSigned;
                           state_q  <= MDU_DIV_RUN;
                        end
                        default: ;
                     endcase
                  end
               end
               MDU_MUL_RUN: begin
                  if (mulLast) begin
                     hi_q    <= mulProd[63:32];
                     lo_q    <= mulProd[31:0];
                     done_q  <= 1'b1;
                     state_q <= MDU_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 6'd1;
                  end
               end
               MDU_DIV_RUN: begin
                  if (cnt_q == 6'd31) begin
                     hi_q    <= divHi;
                     lo_q    <= divLo;
                     done_q  <= 1'b1;
                     state_q <= MDU_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 6'd1;
                  end
               end
               default: state_q <= MDU_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Testbench for mdu_hilo_ctrl: directed and random ops against an arithmetic
// model of HI/LO, with busy latency and done pulse checks.
module tb_mdu_hilo_ctrl;
   import mdu_hilo_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          compareCount;
   int          mismatchCount;
   logic [31:0] expHi;
   logic [31:0] expLo;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 32;
`endif

   mdu_hilo_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src1  (req_src1),
      .req_src2  (req_src2),
      .cancel    (cancel),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         mismatchCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Architectural result of one op, from plain 64-bit arithmetic.
   task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MDU_OP_MULT: begin
            sp = sa * sb;
            expHi = sp[63:32];
            expLo = sp[31:0];
         end
         MDU_OP_MULTU: begin
            up = ua * ub;
            expHi = up[63:32];
            expLo = up[31:0];
         end
         MDU_OP_DIV, MDU_OP_DIVU: begin
            if (b == 32'd0) begin
               expLo = 32'hFFFF_FFFF;
               expHi = a;
            end else if (op == MDU_OP_DIV) begin
               sq = sa / sb;
               sr = sa % sb;
               expLo = sq[31:0];
               expHi = sr[31:0];
            end else begin
               up = ua / ub;
               expLo = up[31:0];
               up = ua % ub;
               expHi = up[31:0];
            end
         end
         MDU_OP_MTHI: expHi = a;
         MDU_OP_MTLO: expLo = a;
         default: ;
      endcase
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge busy is low
   // again so a following call issues back-to-back.
   task automatic applyStimulus(input string tag, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      int cycles;
      int expLat;
      expLat = (op == MDU_OP_MULT || op == MDU_OP_MULTU) ? MUL_LAT :
               (op == MDU_OP_DIV  || op == MDU_OP_DIVU)  ? 32 : 0;
      checkOutput({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      modelOp(op, a, b);
      cycles = 0;
      @(negedge clk);
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         checkOutput({tag, "_doneLow"}, {63'd0, done}, 64'd0);
         checkOutput({tag, "_readyLow"}, {63'd0, req_ready}, 64'd0);
         @(negedge clk);
      end
      checkOutput({tag, "_latency"}, 64'(cycles), 64'(expLat));
      checkOutput({tag, "_done"}, {63'd0, done}, {63'd0, (expLat != 0)});
      checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, expHi});
      checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, expLo});
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      expHi         = 32'd0;
      expLo         = 32'd0;
      reset         = 1'b1;
      req_valid     = 1'b0;
      req_op        = 3'd0;
      req_src1      = 32'd0;
      req_src2      = 32'd0;
      cancel        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_busy",  {63'd0, busy},      64'd0);
      checkOutput("rst_done",  {63'd0, done},      64'd0);
      checkOutput("rst_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("rst_hi",    {32'd0, hi},        64'd0);
      checkOutput("rst_lo",    {32'd0, lo},        64'd0);

      applyStimulus("divu_100_7",  MDU_OP_DIVU, 32'd100, 32'd7);
      checkOutput("divu_lo_const", {32'd0, lo}, 64'd14);
      checkOutput("divu_hi_const", {32'd0, hi}, 64'd2);
      applyStimulus("div_m7_2",    MDU_OP_DIV,  32'hFFFF_FFF9, 32'd2);
      checkOutput("div_lo_const",  {32'd0, lo}, 64'hFFFF_FFFD);
      checkOutput("div_hi_const",  {32'd0, hi}, 64'hFFFF_FFFF);
      applyStimulus("div_ovf",     MDU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("ovf_lo_const",  {32'd0, lo}, 64'h8000_0000);
      checkOutput("ovf_hi_const",  {32'd0, hi}, 64'd0);
      applyStimulus("divu_by0",    MDU_OP_DIVU, 32'd5, 32'd0);
      applyStimulus("div_by0",     MDU_OP_DIV,  32'hFFFF_FFFB, 32'd0);
      applyStimulus("mult",        MDU_OP_MULT,  32'hFFFF_FFFF, 32'd2);
      checkOutput("mult_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
      checkOutput("mult_lo_const", {32'd0, lo}, 64'hFFFF_FFFE);
      applyStimulus("multu",       MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      checkOutput("multu_hi_const", {32'd0, hi}, 64'd1);
      applyStimulus("undef_op",    3'd6, 32'h1111_1111, 32'h2222_2222);

      // MTHI then MTLO on consecutive cycles; busy must stay low throughout.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MDU_OP_MTHI;
      req_src1  = 32'h1234;
      @(posedge clk);
      #1;
      req_op   = MDU_OP_MTLO;
      req_src1 = 32'h5678;
      @(negedge clk);
      checkOutput("mthi_busy", {63'd0, busy}, 64'd0);
      checkOutput("mthi_hi",   {32'd0, hi},   64'h1234);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      expHi = 32'h1234;
      expLo = 32'h5678;
      @(negedge clk);
      checkOutput("mtlo_busy", {63'd0, busy}, 64'd0);
      checkOutput("mtlo_done", {63'd0, done}, 64'd0);
      checkOutput("mtlo_hi",   {32'd0, hi},   64'h1234);
      checkOutput("mtlo_lo",   {32'd0, lo},   64'h5678);

      // Cancel a DIV in its tenth busy cycle; HI/LO must keep prior values.
      req_valid = 1'b1;
      req_op    = MDU_OP_DIV;
      req_src1  = 32'd1000;
      req_src2  = 32'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         checkOutput("cxl_busy", {63'd0, busy}, 64'd1);
         checkOutput("cxl_done", {63'd0, done}, 64'd0);
      end
      @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      @(negedge clk);
      checkOutput("cxl_idle",  {63'd0, busy},      64'd0);
      checkOutput("cxl_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("cxl_nodone", {63'd0, done},     64'd0);
      checkOutput("cxl_hi",    {32'd0, hi},        {32'd0, expHi});
      checkOutput("cxl_lo",    {32'd0, lo},        {32'd0, expLo});
      applyStimulus("post_cxl_divu", MDU_OP_DIVU, 32'd1000, 32'd3);

      // A request coinciding with cancel in IDLE is dropped.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MDU_OP_MTHI;
      req_src1  = 32'hDEAD_BEEF;
      cancel    = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cancel    = 1'b0;
      @(negedge clk);
      checkOutput("idlecxl_hi",   {32'd0, hi},   {32'd0, expHi});
      checkOutput("idlecxl_busy", {63'd0, busy}, 64'd0);

      // Random ops, issued back to back.
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 17));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         applyStimulus("rand", op, a, b);
      end
      @(negedge clk);
      checkOutput("final_done", {63'd0, done}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
